// File: rtl/alu_result_commit.sv
// Commit stage for execute-stage ALU results: buffers bundles in a small FIFO,
// retires one per cycle to the GPR write port and merges flagged bits into EFLAGS.
module alu_result_commit #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32,
   parameter int REG_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [1:0]        in_opsize,
   input  logic [REG_W-1:0]  in_dest,
   input  logic              in_wr_en,
   input  logic [5:0]        in_set_flags,
   input  logic [5:0]        in_flags,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [REG_W-1:0]  wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        wb_be,
   output logic [5:0]        eflags,
   output logic              busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   function automatic logic [3:0] be_of(input logic [1:0] sz);
      logic [3:0] be;
      case (sz)
         2'd0:    be = 4'b0001;
         2'd1:    be = 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Unknown mask bits are treated as "do not update".
   function automatic logic [5:0] mask_of(input logic [5:0] m);
      logic [5:0] r;
      for (int i = 0; i < 6; i++) begin
         r[i] = (m[i] === 1'b1);
      end
      return r;
   endfunction

   function automatic logic [5:0] new_flags(input logic [DATA_W-1:0] res,
                                            input logic [1:0] sz,
                                            input logic [5:0] fl);
      logic [5:0] f;
      f = fl;
      case (sz)
         2'd0: begin
            f[3] = (res[7:0] == 8'h00);
            f[4] = res[7];
         end
         2'd1: begin
            f[3] = (res[15:0] == 16'h0000);
            f[4] = res[15];
         end
         default: begin
            f[3] = (res == {DATA_W{1'b0}});
            f[4] = res[DATA_W-1];
         end
      endcase
      return f;
   endfunction

   logic [DATA_W-1:0] result_r [DEPTH];
   logic [1:0]        opsize_r [DEPTH];
   logic [REG_W-1:0]  dest_r   [DEPTH];
   logic              wr_en_r  [DEPTH];
   logic [5:0]        mask_r   [DEPTH];
   logic [5:0]        flags_r  [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [5:0]        eflags_r;

   logic              head_valid_s;
   logic              enq_s;
   logic              retire_s;
   logic [5:0]        head_mask_s;
   logic [5:0]        head_flags_s;

   assign in_ready     = (count_r < CNT_W'(DEPTH));
   assign head_valid_s = (count_r != {CNT_W{1'b0}});
   assign busy         = head_valid_s;
   assign eflags       = eflags_r;
   assign wb_dest      = dest_r[rd_ptr_r];
   assign wb_data      = result_r[rd_ptr_r];
   assign wb_be        = be_of(opsize_r[rd_ptr_r]);
   assign wb_valid     = head_valid_s & wr_en_r[rd_ptr_r];
   assign head_mask_s  = mask_r[rd_ptr_r];
   assign head_flags_s = new_flags(result_r[rd_ptr_r], opsize_r[rd_ptr_r], flags_r[rd_ptr_r]);

   // Handshake decode: flags-only heads retire without waiting on the register file.
   always_comb begin
      enq_s    = in_valid & in_ready & ~flush;
      retire_s = 1'b0;
      if (head_valid_s) begin
         retire_s = wr_en_r[rd_ptr_r] ? wb_ready : 1'b1;
      end else begin
         retire_s = 1'b0;
      end
   end

   // Entry payload storage; contents are only meaningful while counted.
   always_ff @(posedge clk) begin
      if (enq_s) begin
         result_r[wr_ptr_r] <= in_result;
         opsize_r[wr_ptr_r] <= in_opsize;
         dest_r[wr_ptr_r]   <= in_dest;
         wr_en_r[wr_ptr_r]  <= in_wr_en;
         mask_r[wr_ptr_r]   <= mask_of(in_set_flags);
         flags_r[wr_ptr_r]  <= in_flags;
      end
   end

   // Pointer/count control and architectural flag commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         eflags_r <= 6'b000000;
      end else begin
         // A retire coinciding with flush still commits its flags.
         if (retire_s) begin
            eflags_r <= (head_mask_s & head_flags_s) | (~head_mask_s & eflags_r);
         end
         if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
         end else begin
            if (enq_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (retire_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq_s, retire_s})
               2'b10:   count_r <= count_r + CNT_W'(1);
               2'b01:   count_r <= count_r - CNT_W'(1);
               default: count_r <= count_r;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_result_commit.sv
// Directed bench for alu_result_commit: GPR writes are scoreboarded through a queue,
// flag and status outputs are checked against constants at each step.
module tb_alu_result_commit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_result = 32'h0;
   logic [1:0]  in_opsize = 2'd0;
   logic [2:0]  in_dest = 3'd0;
   logic        in_wr_en = 1'b0;
   logic [5:0]  in_set_flags = 6'b0;
   logic [5:0]  in_flags = 6'b0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [2:0]  wb_dest;
   logic [31:0] wb_data;
   logic [3:0]  wb_be;
   logic [5:0]  eflags;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;
   logic [38:0] sb_q[$];

   alu_result_commit #(.DEPTH(2), .DATA_W(32), .REG_W(3)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_opsize(in_opsize), .in_dest(in_dest), .in_wr_en(in_wr_en),
      .in_set_flags(in_set_flags), .in_flags(in_flags),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest),
      .wb_data(wb_data), .wb_be(wb_be), .eflags(eflags), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] exp_be(input logic [1:0] sz);
      case (sz)
         2'd0:    return 4'b0001;
         2'd1:    return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop on each accepted write, then apply flush/reset, then push new accepts.
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
      end else begin
         if (wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_wb", {wb_dest, wb_data, wb_be}, 64'h0);
            end else begin
               chk("wb_entry", {wb_dest, wb_data, wb_be}, sb_q.pop_front());
            end
         end
         if (flush) begin
            sb_q.delete();
         end else if (in_valid && in_ready && in_wr_en) begin
            sb_q.push_back({in_dest, in_result, exp_be(in_opsize)});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] res, input logic [1:0] sz, input logic [2:0] dst,
                        input logic we, input logic [5:0] mask, input logic [5:0] fl);
      in_valid = 1'b1; in_result = res; in_opsize = sz; in_dest = dst;
      in_wr_en = we; in_set_flags = mask; in_flags = fl;
   endtask

   initial begin
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_eflags", eflags, 6'b000000);

      // ADD 8b: SF computed from bit 7, ZF=0
      wb_ready = 1'b1;
      drive(32'h00000080, 2'd0, 3'd1, 1'b1, 6'b111111, 6'b100011);
      cyc();
      in_valid = 1'b0;
      chk("add_wb_valid", wb_valid, 1'b1);
      chk("add_busy", busy, 1'b1);
      chk("add_be", wb_be, 4'b0001);
      cyc();
      chk("add_eflags", eflags, 6'b110011);
      chk("add_busy_after", busy, 1'b0);

      // Preload eflags=000100 with a flags-only op, then AND 32b giving zero
      drive(32'h00000001, 2'd2, 3'd0, 1'b0, 6'b111111, 6'b000100);
      cyc();
      in_valid = 1'b0;
      cyc();
      chk("preload_eflags", eflags, 6'b000100);
      drive(32'h00000000, 2'd2, 3'd2, 1'b1, 6'b111011, 6'b000001);
      cyc();
      in_valid = 1'b0;
      cyc();
      chk("and_eflags", eflags, 6'b001101);

      // Flags-only CF update: no write pulse, CF lands one cycle after head
      drive(32'h00001234, 2'd1, 3'd3, 1'b0, 6'b000010, 6'b000010);
      cyc();
      in_valid = 1'b0;
      chk("fo_wb_valid", wb_valid, 1'b0);
      chk("fo_busy", busy, 1'b1);
      chk("fo_eflags_hold", eflags, 6'b001101);
      cyc();
      chk("fo_eflags", eflags, 6'b001111);
      chk("fo_busy_after", busy, 1'b0);

      // Backpressure: three back-to-back, third held until space frees
      wb_ready = 1'b0;
      drive(32'h0000BEEF, 2'd1, 3'd4, 1'b1, 6'b000000, 6'b111111);
      cyc();
      chk("bp_ready1", in_ready, 1'b1);
      drive(32'hCAFEF00D, 2'd3, 3'd5, 1'b1, 6'b000000, 6'b111111);
      cyc();
      chk("bp_ready2", in_ready, 1'b0);
      drive(32'h12345678, 2'd2, 3'd6, 1'b1, 6'b000000, 6'b111111);
      cyc();
      chk("bp_ready_held", in_ready, 1'b0);
      chk("bp_wb_valid", wb_valid, 1'b1);
      wb_ready = 1'b1;
      chk("bp_full_deq_ready", in_ready, 1'b0);
      cyc();
      chk("bp_ready_after1", in_ready, 1'b1);
      cyc();
      in_valid = 1'b0;
      chk("bp_busy_mid", busy, 1'b1);
      cyc();
      chk("bp_busy_done", busy, 1'b0);
      chk("bp_eflags", eflags, 6'b001111);

      // Flush with two entries and a same-cycle enqueue
      wb_ready = 1'b0;
      drive(32'h00000000, 2'd2, 3'd1, 1'b1, 6'b111111, 6'b000000);
      cyc();
      drive(32'h00000000, 2'd2, 3'd2, 1'b1, 6'b111111, 6'b000000);
      cyc();
      flush = 1'b1;
      drive(32'h00000000, 2'd2, 3'd3, 1'b1, 6'b111111, 6'b000000);
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_busy", busy, 1'b0);
      chk("fl_wb_valid", wb_valid, 1'b0);
      chk("fl_eflags", eflags, 6'b001111);
      cyc();
      chk("fl_busy2", busy, 1'b0);

      // Flush coinciding with a retire: write and PF commit still happen, enqueue dropped
      drive(32'h000000AA, 2'd0, 3'd7, 1'b1, 6'b000001, 6'b000000);
      cyc();
      wb_ready = 1'b1; flush = 1'b1;
      drive(32'h00000000, 2'd2, 3'd1, 1'b1, 6'b111111, 6'b111111);
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("flr_eflags", eflags, 6'b001110);
      chk("flr_busy", busy, 1'b0);

      // Reset with a full FIFO
      wb_ready = 1'b0;
      drive(32'h00000005, 2'd2, 3'd1, 1'b1, 6'b111111, 6'b111111);
      cyc();
      cyc();
      chk("pre_rst_ready", in_ready, 1'b0);
      reset = 1'b1;
      cyc();
      reset = 1'b0; in_valid = 1'b0;
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_eflags", eflags, 6'b000000);
      chk("mrst_in_ready", in_ready, 1'b1);
      chk("mrst_wb_valid", wb_valid, 1'b0);
      cyc();
      chk("sb_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
